// File: rtl/spi_pkg.sv
// Shared definitions for the SPI digit receiver: default frame geometry and FSM encoding.
package spi_pkg;

  localparam int SPI_WIDTH       = 8;
  localparam int SPI_SYNC_STAGES = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchronizer for one asynchronous input, with registered-history edge detect.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              prev;
  logic [STAGES:0]   fill;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync <= {STAGES{RST_VAL}};
      prev <= RST_VAL;
      fill <= '0;
    end else begin
      sync <= {sync[STAGES-2:0], din};
      prev <= sync[STAGES-1];
      fill <= {fill[STAGES-1:0], 1'b1};
    end
  end

  // Edges are suppressed until the chain holds only real samples, so the reset
  // value never masquerades as a transition (e.g. cs_n held low through reset).
  assign level = sync[STAGES-1];
  assign rise  = fill[STAGES] &  level & ~prev;
  assign fall  = fill[STAGES] & ~level &  prev;

endmodule

// File: rtl/spi_slave_digit.sv
// SPI mode-0 slave: receives bytes for the seven-segment digit and echoes the previous byte on miso.
module spi_slave_digit
  import spi_pkg::*;
#(
  parameter int WIDTH       = SPI_WIDTH,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             frame_err,
  output logic             state_dbg
);

  localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  // rx_valid is a bare one-cycle strobe with no ready: the display controller
  // must take rx_data in the cycle rx_valid is high; rx_data then holds until the next strobe.

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;
  logic unused_sclk_level, unused_cs_level, unused_mosi_rise, unused_mosi_fall;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .reset(reset), .din(sclk),
    .level(unused_sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .reset(reset), .din(cs_n),
    .level(unused_cs_level), .rise(cs_rise), .fall(cs_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .reset(reset), .din(mosi),
    .level(mosi_s), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
  );

  spi_state_t       state, state_nxt;
  logic [CNT_W-1:0] bit_cnt, cnt_nxt;
  logic [WIDTH-1:0] rx_shift, rx_shift_nxt;
  logic [WIDTH-1:0] tx_shift, tx_nxt;
  logic [WIDTH-1:0] rx_data_nxt;
  logic [WIDTH-1:0] rx_byte;
  logic             valid_nxt, err_nxt, miso_nxt;

  assign rx_byte = {rx_shift[WIDTH-2:0], mosi_s};

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = bit_cnt;
    rx_shift_nxt = rx_shift;
    tx_nxt       = tx_shift;
    rx_data_nxt  = rx_data;
    valid_nxt    = 1'b0;
    err_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_nxt = SHIFT;
          cnt_nxt   = '0;
          tx_nxt    = rx_data;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          // Deselect beats a coincident sclk rise; any partial byte is dropped.
          state_nxt = IDLE;
          err_nxt   = (bit_cnt != '0);
          cnt_nxt   = '0;
        end else if (sclk_rise) begin
          rx_shift_nxt = rx_byte;
          if (bit_cnt == LAST_BIT) begin
            rx_data_nxt = rx_byte;
            valid_nxt   = 1'b1;
            cnt_nxt     = '0;
            tx_nxt      = rx_byte;
          end else begin
            cnt_nxt = bit_cnt + 1'b1;
          end
        end else if (sclk_fall && (bit_cnt != '0)) begin
          // The fall after a byte's last rise keeps the freshly reloaded MSB on miso.
          tx_nxt = {tx_shift[WIDTH-2:0], 1'b0};
        end
      end
      default: state_nxt = IDLE;
    endcase
    miso_nxt = (state_nxt == SHIFT) & tx_nxt[WIDTH-1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      miso      <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= cnt_nxt;
      rx_shift  <= rx_shift_nxt;
      tx_shift  <= tx_nxt;
      rx_data   <= rx_data_nxt;
      rx_valid  <= valid_nxt;
      frame_err <= err_nxt;
      miso      <= miso_nxt;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_spi_slave_digit.sv
// Bench for spi_slave_digit: table-driven frames, hand-written corner sequences and random frames.
module tb_spi_slave_digit;

  localparam int W    = 8;
  localparam int HALF = 5;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         sclk = 1'b0;
  logic         cs_n = 1'b1;
  logic         mosi = 1'b0;
  logic         miso;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         frame_err;
  logic         state_dbg;

  spi_slave_digit dut (
    .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_err(frame_err), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int           n_vec = 0;
  int           n_err = 0;
  int           valid_cnt = 0;
  int           err_cnt = 0;
  logic         chk_idle = 1'b0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] frame_q[$];
  logic [W-1:0] disp_model = '0;
  logic [W-1:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt++;
      if (exp_q.size() == 0) begin
        check("rx_valid_unexpected", {31'b0, rx_valid}, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("rx_data_at_valid", {24'b0, rx_data}, {24'b0, mon_exp});
      end
    end
    if (frame_err) err_cnt++;
    if (rx_valid || frame_err)
      check("valid_err_exclusive", {31'b0, rx_valid & frame_err}, 32'd0);
    if (chk_idle) check("miso_idle", {31'b0, miso}, 32'd0);
  end

  // ---------------- drivers ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_assert();
    @(negedge clk);
    cs_n = 1'b0;
    wait_cycles(6);
  endtask

  task automatic cs_release();
    wait_cycles(4);
    cs_n = 1'b1;
    wait_cycles(8);
  endtask

  // Master side of mode 0: data set while sclk low, miso sampled on the rise.
  task automatic send_bits(input logic [W-1:0] b, input int nbits, output logic [W-1:0] echo);
    echo = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = b[W-1-i];
      wait_cycles(HALF);
      sclk = 1'b1;
      echo[W-1-i] = miso;
      wait_cycles(HALF);
      sclk = 1'b0;
    end
  endtask

  // Sends every byte queued in frame_q inside one cs_n frame, then optional partial bits.
  task automatic apply_frame(input string name, input int part_bits, input logic [W-1:0] part,
                             input logic [W-1:0] exp_rx, input int exp_valid, input int exp_err);
    int           v0;
    int           e0;
    logic [W-1:0] b;
    logic [W-1:0] echo;
    v0 = valid_cnt;
    e0 = err_cnt;
    cs_assert();
    while (frame_q.size() > 0) begin
      b = frame_q.pop_front();
      exp_q.push_back(b);
      send_bits(b, W, echo);
      check({name, "_echo"}, {24'b0, echo}, {24'b0, disp_model});
      disp_model = b;
    end
    if (part_bits > 0) send_bits(part, part_bits, echo);
    cs_release();
    check({name, "_rx_data"}, {24'b0, rx_data}, {24'b0, exp_rx});
    check({name, "_valid_pulses"}, valid_cnt - v0, exp_valid);
    check({name, "_err_pulses"}, err_cnt - e0, exp_err);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [W-1:0] b0;
    logic [W-1:0] b1;
    int           nbytes;
    int           part_bits;
    logic [W-1:0] part;
    logic [W-1:0] exp_rx;
    int           exp_valid;
    int           exp_err;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [W-1:0] echo;
    logic [W-1:0] exp_rx;
    int           nbytes;
    int           part_bits;
    int           v0;
    int           e0;

    vecs[0] = '{8'hA5, 8'h00, 1, 0, 8'h00, 8'hA5, 1, 0};
    vecs[1] = '{8'h3C, 8'hFF, 2, 0, 8'h00, 8'hFF, 2, 0};
    vecs[2] = '{8'h00, 8'h00, 0, 5, 8'h12, 8'hFF, 0, 1};
    vecs[3] = '{8'h01, 8'h00, 1, 0, 8'h00, 8'h01, 1, 0};

    // Reset held with sclk/mosi noise.
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      sclk = 1'($urandom_range(0, 1));
      mosi = 1'($urandom_range(0, 1));
      check("reset_outputs", {21'b0, rx_data, rx_valid, frame_err, miso, state_dbg}, 32'd0);
    end
    sclk = 1'b0;
    mosi = 1'b0;
    reset = 1'b1;
    wait_cycles(5);

    // Table-driven frames: single byte, two-byte frame, abort, recovery.
    for (int i = 0; i < 4; i++) begin
      if (vecs[i].nbytes > 0) frame_q.push_back(vecs[i].b0);
      if (vecs[i].nbytes > 1) frame_q.push_back(vecs[i].b1);
      apply_frame($sformatf("vec%0d", i), vecs[i].part_bits, vecs[i].part,
                  vecs[i].exp_rx, vecs[i].exp_valid, vecs[i].exp_err);
    end

    // Reset mid-byte, then a frame already in progress at release is ignored.
    cs_assert();
    send_bits(8'hE7, 3, echo);
    reset = 1'b0;
    wait_cycles(2);
    check("reset_mid_outputs", {21'b0, rx_data, rx_valid, frame_err, miso, state_dbg}, 32'd0);
    disp_model = '0;
    wait_cycles(2);
    reset = 1'b1;
    v0 = valid_cnt;
    e0 = err_cnt;
    send_bits(8'h99, W, echo);
    cs_release();
    check("stale_frame_valid", valid_cnt - v0, 0);
    check("stale_frame_err", err_cnt - e0, 0);
    check("stale_frame_rx", {24'b0, rx_data}, 32'd0);
    frame_q.push_back(8'h42);
    apply_frame("after_reset", 0, 8'h00, 8'h42, 1, 0);

    // Idle sclk noise with cs_n high.
    v0 = valid_cnt;
    chk_idle = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sclk = ~sclk;
      mosi = 1'($urandom_range(0, 1));
      wait_cycles(HALF);
    end
    sclk = 1'b0;
    wait_cycles(HALF);
    chk_idle = 1'b0;
    check("idle_noise_valid", valid_cnt - v0, 0);

    // Eighth sclk rise coincident with cs_n rise.
    v0 = valid_cnt;
    e0 = err_cnt;
    cs_assert();
    send_bits(8'h5A, 7, echo);
    mosi = 1'b0;
    wait_cycles(HALF);
    sclk = 1'b1;
    cs_n = 1'b1;
    wait_cycles(HALF);
    sclk = 1'b0;
    wait_cycles(8);
    check("collision_err", err_cnt - e0, 1);
    check("collision_valid", valid_cnt - v0, 0);
    check("collision_rx", {24'b0, rx_data}, {24'b0, disp_model});

    // Random frames against the display-value model.
    for (int f = 0; f < 25; f++) begin
      nbytes    = $urandom_range(0, 3);
      part_bits = ($urandom_range(0, 2) == 0) ? $urandom_range(1, W - 1) : 0;
      exp_rx    = disp_model;
      for (int k = 0; k < nbytes; k++) begin
        exp_rx = W'($urandom_range(0, 255));
        frame_q.push_back(exp_rx);
      end
      apply_frame($sformatf("rand%0d", f), part_bits, W'($urandom_range(0, 255)),
                  exp_rx, nbytes, (part_bits > 0) ? 1 : 0);
    end

    wait_cycles(5);
    check("exp_q_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
